ps2_keyboard_rx: RTL and testbench



---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_keyboard_rx_if.sv | 24 ++
 rtl/ps2_clk_filter.sv | 52 +++++
 rtl/ps2_keyboard_rx.sv | 183 ++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: scan-code prefixes, receiver FSM states,
// and keypad make codes used by downstream password logic.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam logic [7:0] KP_5 = 8'h73;
    localparam logic [7:0] KP_6 = 8'h74;
    localparam logic [7:0] KP_3 = 8'h7A;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } ps2_state_e;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
        return (^b) ^ p;
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Decoded key output bundle of the PS/2 receiver.
// master: receiver drives data/strobes; slave: consumer samples them.
interface ps2_keyboard_rx_if;
    import ps2_pkg::*;

    logic [7:0] ps2_data;
    logic       ps2_new_data;
    logic       ps2_ext;
    logic       frame_err;

    modport master (
        output ps2_data,
        output ps2_new_data,
        output ps2_ext,
        output frame_err
    );

    modport slave (
        input ps2_data,
        input ps2_new_data,
        input ps2_ext,
        input frame_err
    );
endinterface

// File: rtl/ps2_clk_filter.sv
// Synchronizes raw PS/2 clock/data and debounces the clock line.
// Ports: clk, reset, ps2_clk/ps2_dat (raw) -> fall_tick, dat_s.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic fall_tick,
    output logic dat_s
);
    logic [1:0]            csync_q, csync_d;
    logic [1:0]            dsync_q, dsync_d;
    logic [FILTER_LEN-1:0] hist_q, hist_d;
    logic                  clk_f_q, clk_f_d;
    logic                  fall_q, fall_d;

    always_comb begin
        csync_d = {csync_q[0], ps2_clk};
        dsync_d = {dsync_q[0], ps2_dat};
        hist_d  = {hist_q[FILTER_LEN-2:0], csync_q[1]};
        clk_f_d = clk_f_q;
        // Level only moves once the whole window agrees; mixed windows hold.
        if (&hist_q) begin
            clk_f_d = 1'b1;
        end else if (hist_q == '0) begin
            clk_f_d = 1'b0;
        end
        fall_d = clk_f_q & ~clk_f_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csync_q <= 2'b11;
            dsync_q <= 2'b11;
            hist_q  <= '1;
            clk_f_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            csync_q <= csync_d;
            dsync_q <= dsync_d;
            hist_q  <= hist_d;
            clk_f_q <= clk_f_d;
            fall_q  <= fall_d;
        end
    end

    assign fall_tick = fall_q;
    assign dat_s     = dsync_q[1];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frames bytes, checks parity/stop, strips F0/E0.
// Ports: clk, reset, ps2_clk, ps2_dat; out_if carries data/strobes/err.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ps2_clk,
    input  logic               ps2_dat,
    ps2_keyboard_rx_if.master  out_if
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic fall_tick;
    logic dat_s;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .fall_tick (fall_tick),
        .dat_s     (dat_s)
    );

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_ok_q, byte_ok_d;
    logic          err_q, err_d;
    logic          timeout;

    logic          break_pend_q, break_pend_d;
    logic          ext_pend_q, ext_pend_d;
    logic [7:0]    data_q, data_d;
    logic          ext_q, ext_d;
    logic          new_q, new_d;
    logic          ferr_q, ferr_d;

    // A fall_tick in the same cycle restarts the window instead of expiring it.
    assign timeout = (state_q != S_IDLE) && !fall_tick && (tmo_q == TMO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (fall_tick && !dat_s) state_d = S_DATA;
            S_DATA:   if (fall_tick && bit_cnt_q == 3'd7) state_d = S_PARITY;
            S_PARITY: if (fall_tick) state_d = S_STOP;
            S_STOP:   if (fall_tick) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (timeout) state_d = S_IDLE;
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        byte_ok_d = 1'b0;
        err_d     = 1'b0;
        if (state_q == S_IDLE || fall_tick) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (fall_tick && !dat_s) bit_cnt_d = 3'd0;
            end
            S_DATA: begin
                if (fall_tick) begin
                    shift_d = {dat_s, shift_q[7:1]};
                    if (bit_cnt_q != 3'd7) bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            S_PARITY: begin
                if (fall_tick) par_d = dat_s;
            end
            S_STOP: begin
                if (fall_tick) begin
                    byte_ok_d = dat_s && odd_parity_ok(shift_q, par_q);
                    err_d     = !byte_ok_d;
                end
            end
            default: ;
        endcase
        if (timeout) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            byte_ok_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            byte_ok_q <= byte_ok_d;
            err_q     <= err_d;
        end
    end

    // Scan-code decoder; shift_q still holds the byte while byte_ok_q is high.
    logic is_brk, is_ext, is_rel, is_make;

    always_comb begin
        is_brk  = byte_ok_q && (shift_q == SC_BREAK);
        is_ext  = byte_ok_q && (shift_q == SC_EXT);
        is_rel  = byte_ok_q && !is_brk && !is_ext && break_pend_q;
        is_make = byte_ok_q && !is_brk && !is_ext && !break_pend_q;

        break_pend_d = break_pend_q;
        ext_pend_d   = ext_pend_q;
        data_d       = data_q;
        ext_d        = ext_q;
        new_d        = 1'b0;
        ferr_d       = err_q;

        unique case (1'b1)
            is_brk: break_pend_d = 1'b1;
            is_ext: ext_pend_d = 1'b1;
            is_rel: begin
                break_pend_d = 1'b0;
                ext_pend_d   = 1'b0;
            end
            is_make: begin
                data_d     = shift_q;
                ext_d      = ext_pend_q;
                new_d      = 1'b1;
                ext_pend_d = 1'b0;
            end
            default: ;
        endcase

        if (err_q) begin
            break_pend_d = 1'b0;
            ext_pend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            break_pend_q <= 1'b0;
            ext_pend_q   <= 1'b0;
            data_q       <= 8'h00;
            ext_q        <= 1'b0;
            new_q        <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            break_pend_q <= break_pend_d;
            ext_pend_q   <= ext_pend_d;
            data_q       <= data_d;
            ext_q        <= ext_d;
            new_q        <= new_d;
            ferr_q       <= ferr_d;
        end
    end

    assign out_if.ps2_data     = data_q;
    assign out_if.ps2_ext      = ext_q;
    assign out_if.ps2_new_data = new_q;
    assign out_if.frame_err    = ferr_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: frames, prefixes, errors,
// timeout, clock glitches and mid-frame reset.
module tb_ps2_keyboard_rx;
    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 400;
    localparam int HALF        = 20;
    localparam int GAP         = 40;

    logic clk = 1'b0;
    logic reset;
    logic ps2_clk;
    logic ps2_dat;

    ps2_keyboard_rx_if rx_if ();

    ps2_keyboard_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .out_if  (rx_if.master)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    int cyc = 0;
    int n_new = 0;
    int n_err = 0;
    int viol = 0;
    int err_cyc = 0;
    int last_fall = 0;
    logic new_prev = 1'b0;
    logic err_prev = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_if.ps2_new_data) n_new++;
        if (rx_if.frame_err) begin
            n_err++;
            err_cyc = cyc;
        end
        if (rx_if.ps2_new_data && rx_if.frame_err) viol++;
        if (rx_if.ps2_new_data && new_prev) viol++;
        if (rx_if.frame_err && err_prev) viol++;
        new_prev = rx_if.ps2_new_data;
        err_prev = rx_if.frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input int nbits, input bit glitch);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = f[i];
            if (glitch) begin
                wait_cyc(4);
                ps2_clk = 1'b0;
                wait_cyc(FILTER_LEN - 2);
                ps2_clk = 1'b1;
                wait_cyc(HALF - 4 - (FILTER_LEN - 2));
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk = 1'b0;
            last_fall = cyc;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        wait_cyc(GAP);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 11, 1'b0);
    endtask

    int n0, e0, lat;

    initial begin
        reset   = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(20);

        check("rst_data", rx_if.ps2_data, 8'h00);
        check("rst_new",  rx_if.ps2_new_data, 1'b0);
        check("rst_ext",  rx_if.ps2_ext, 1'b0);
        check("rst_err",  rx_if.frame_err, 1'b0);

        // 1: plain make code
        n0 = n_new; e0 = n_err;
        send(8'h73);
        check("t1_new",  n_new - n0, 1);
        check("t1_data", rx_if.ps2_data, 8'h73);
        check("t1_ext",  rx_if.ps2_ext, 1'b0);
        check("t1_err",  n_err - e0, 0);

        // 2: break sequence suppressed
        n0 = n_new;
        send(8'hF0);
        send(8'h73);
        check("t2_new",  n_new - n0, 0);
        check("t2_hold", rx_if.ps2_data, 8'h73);
        n0 = n_new;
        send(8'h74);
        check("t2_new2", n_new - n0, 1);
        check("t2_data", rx_if.ps2_data, 8'h74);

        // 3: extended make, then extended break
        n0 = n_new;
        send(8'hE0);
        send(8'h74);
        check("t3_new",  n_new - n0, 1);
        check("t3_data", rx_if.ps2_data, 8'h74);
        check("t3_ext",  rx_if.ps2_ext, 1'b1);
        n0 = n_new;
        send(8'hE0);
        send(8'hF0);
        send(8'h74);
        check("t3_rel",  n_new - n0, 0);
        n0 = n_new;
        send(8'h73);
        check("t3_clr",  n_new - n0, 1);
        check("t3_ext0", rx_if.ps2_ext, 1'b0);
        check("t3_d73",  rx_if.ps2_data, 8'h73);

        // 4: parity error, then good frame
        n0 = n_new; e0 = n_err;
        send_frame(8'h7A, 1'b1, 11, 1'b0);
        check("t4_err",  n_err - e0, 1);
        check("t4_nonew", n_new - n0, 0);
        check("t4_hold", rx_if.ps2_data, 8'h73);
        n0 = n_new;
        send(8'h7A);
        check("t4_new",  n_new - n0, 1);
        check("t4_data", rx_if.ps2_data, 8'h7A);

        // 5: timeout after start + 3 data bits
        n0 = n_new; e0 = n_err;
        send_frame(8'h73, 1'b0, 4, 1'b0);
        wait_cyc(TIMEOUT_CYC + 40);
        lat = err_cyc - last_fall;
        check("t5_err",  n_err - e0, 1);
        check("t5_nonew", n_new - n0, 0);
        check("t5_lat_lo", lat >= TIMEOUT_CYC + 2, 1'b1);
        check("t5_lat_hi", lat <= TIMEOUT_CYC + 25, 1'b1);
        n0 = n_new;
        send(8'h73);
        check("t5_new",  n_new - n0, 1);
        check("t5_data", rx_if.ps2_data, 8'h73);

        // 6: short clock glitches, then reset mid-frame
        n0 = n_new; e0 = n_err;
        send_frame(8'h74, 1'b0, 11, 1'b1);
        check("t6_gnew",  n_new - n0, 1);
        check("t6_gdata", rx_if.ps2_data, 8'h74);
        check("t6_gerr",  n_err - e0, 0);
        send(8'hE0);
        send_frame(8'h7A, 1'b0, 5, 1'b0);
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(20);
        check("t6_rdata", rx_if.ps2_data, 8'h00);
        check("t6_rext",  rx_if.ps2_ext, 1'b0);
        check("t6_rnew",  rx_if.ps2_new_data, 1'b0);
        check("t6_rerr",  rx_if.frame_err, 1'b0);
        n0 = n_new; e0 = n_err;
        send(8'h7A);
        check("t6_new",  n_new - n0, 1);
        check("t6_data", rx_if.ps2_data, 8'h7A);
        check("t6_ext",  rx_if.ps2_ext, 1'b0);
        check("t6_err",  n_err - e0, 0);

        check("pulse_rules", viol, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
